// File: rtl/aging_mon_pkg.sv
// rtl/aging_mon_pkg.sv - shared types, constants and read-map decode for the RO aging monitor
//
// Purpose : FSM state encoding, sweep counter width and read-address region
//           helpers shared by ro_aging_monitor and its sub-module.
// Ports   : none (package)

package aging_mon_pkg;

   localparam int SWEEP_CNT_W = 16;

   typedef enum logic [2:0] {
      IDLE,
      SETTLE,
      COUNT,
      STORE,
      DONE
   } monState_e;

   // Addresses 0..numOsc-1 map to the latest counts.
   function automatic logic isResultAddr(input int unsigned addr, input int unsigned numOsc);
      return addr < numOsc;
   endfunction

   // Addresses numOsc..2*numOsc-1 map to the baselines.
   function automatic logic isBaselineAddr(input int unsigned addr, input int unsigned numOsc);
      return (addr >= numOsc) && (addr < 2 * numOsc);
   endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// rtl/ro_edge_counter.sv - oscillator synchroniser, rising-edge detect and saturating counter
//
// Purpose : Brings every oscillator into the clk domain through a free-running
//           2-flop synchroniser plus a history flop, picks the rising-edge
//           detect of the selected channel and counts it into a CNT_W
//           saturating counter.
// Ports   : clk, rstn        - clock, asynchronous active-low reset
//           osc  [NUM_OSC]   - raw oscillator outputs (asynchronous)
//           sel  [SEL_W]     - channel whose edges are counted
//           clr              - synchronous clear of the counter (priority)
//           cntEn            - count window; detects outside it are dropped
//           count [CNT_W]    - current edge count

module ro_edge_counter #(
   parameter int NUM_OSC = 10,
   parameter int CNT_W   = 24,
   parameter int SEL_W   = 4
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic [NUM_OSC-1:0] osc,
   input  logic [SEL_W-1:0]   sel,
   input  logic               clr,
   input  logic               cntEn,
   output logic [CNT_W-1:0]   count
);

   logic [NUM_OSC-1:0] syncA;
   logic [NUM_OSC-1:0] syncB;
   logic [NUM_OSC-1:0] hist;
   logic [NUM_OSC-1:0] rise;
   logic               hit;

   // All channels are synchronised continuously so a channel switch never
   // sees a stale synchroniser pipeline.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         syncA <= '0;
         syncB <= '0;
         hist  <= '0;
      end else begin
         syncA <= osc;
         syncB <= syncA;
         hist  <= syncB;
      end
   end

   assign rise = syncB & ~hist;
   assign hit  = rise[sel];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (cntEn && hit && (count != {CNT_W{1'b1}})) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/ro_aging_monitor.sv
// rtl/ro_aging_monitor.sv - ring-oscillator aging monitor: sweep sequencer, result memory, alarm
//
// Purpose : Sequences NUM_OSC ring oscillators one at a time through a settle
//           window and a measurement window, stores each edge count, and
//           (with AGING_ALARM_EN defined) compares against a first-sweep
//           baseline to raise sticky per-channel aging alarms.
// Macro   : AGING_ALARM_EN - builds baseline storage and the alarm compare;
//           when undefined baselines read 0 and the alarm outputs are 0.
// Ports   : clk, rstn              - clock, asynchronous active-low reset
//           start_i                - start a sweep (honoured only in IDLE)
//           cont_i                 - continuous mode, sampled in DONE
//           osc_i [NUM_OSC]        - oscillator outputs
//           thresh_i [CNT_W]       - alarm threshold on count drop
//           test_en_o [NUM_OSC]    - one-hot oscillator enable
//           busy_o, done_o         - sweep in progress, end-of-sweep pulse
//           sweep_cnt_o [16]       - completed sweeps (wrapping)
//           rd_en_i, rd_addr_i     - read request and address
//           rd_data_o, rd_valid_o  - registered read data and valid pulse
//           alarm_o, alarm_mask_o  - any alarm, sticky per-channel alarms

module ro_aging_monitor
   import aging_mon_pkg::*;
#(
   parameter int NUM_OSC       = 10,
   parameter int CNT_W         = 24,
   parameter int WIN_CYCLES    = 1024,
   parameter int SETTLE_CYCLES = 16,
   parameter int ADDR_W        = 5
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   start_i,
   input  logic                   cont_i,
   input  logic [NUM_OSC-1:0]     osc_i,
   input  logic [CNT_W-1:0]       thresh_i,
   output logic [NUM_OSC-1:0]     test_en_o,
   output logic                   busy_o,
   output logic                   done_o,
   output logic [SWEEP_CNT_W-1:0] sweep_cnt_o,
   input  logic                   rd_en_i,
   input  logic [ADDR_W-1:0]      rd_addr_i,
   output logic [CNT_W-1:0]       rd_data_o,
   output logic                   rd_valid_o,
   output logic                   alarm_o,
   output logic [NUM_OSC-1:0]     alarm_mask_o
);

   localparam int SEL_W   = (NUM_OSC > 1) ? $clog2(NUM_OSC) : 1;
   localparam int TMR_MAX = (WIN_CYCLES > SETTLE_CYCLES) ? WIN_CYCLES : SETTLE_CYCLES;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   localparam logic [SEL_W-1:0] LAST_SEL    = SEL_W'(NUM_OSC - 1);
   localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
   localparam logic [TMR_W-1:0] WIN_LAST    = TMR_W'(WIN_CYCLES - 1);

   monState_e              state;
   monState_e              stateNext;
   logic [SEL_W-1:0]       sel;
   logic [TMR_W-1:0]       tmr;
   logic [SWEEP_CNT_W-1:0] sweepCnt;
   logic                   firstSweep;
   logic [CNT_W-1:0]       count;
   logic [CNT_W-1:0]       result [NUM_OSC];
   logic [CNT_W-1:0]       rdData;
   logic                   rdValid;
   logic [NUM_OSC-1:0]     alarmMask;
   logic [NUM_OSC-1:0]     selOneHot;
   logic [NUM_OSC-1:0]     testEn;
   logic                   busy;
   logic                   done;
   logic                   cntClr;
   logic                   cntEn;
   logic                   storeEn;
   logic [SEL_W-1:0]       rdIdx;

   assign selOneHot = NUM_OSC'(1) << sel;
   assign rdIdx     = rd_addr_i[SEL_W-1:0];

   ro_edge_counter #(
      .NUM_OSC (NUM_OSC),
      .CNT_W   (CNT_W),
      .SEL_W   (SEL_W)
   ) uEdgeCnt (
      .clk   (clk),
      .rstn  (rstn),
      .osc   (osc_i),
      .sel   (sel),
      .clr   (cntClr),
      .cntEn (cntEn),
      .count (count)
   );

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   always_comb begin
      stateNext = state;
      testEn    = '0;
      busy      = 1'b0;
      done      = 1'b0;
      cntClr    = 1'b0;
      cntEn     = 1'b0;
      storeEn   = 1'b0;
      case (state)
         IDLE: begin
            if (start_i) begin
               stateNext = SETTLE;
            end
         end
         SETTLE: begin
            busy   = 1'b1;
            testEn = selOneHot;
            cntClr = 1'b1;
            if (tmr == SETTLE_LAST) begin
               stateNext = COUNT;
            end
         end
         COUNT: begin
            busy   = 1'b1;
            testEn = selOneHot;
            cntEn  = 1'b1;
            if (tmr == WIN_LAST) begin
               stateNext = STORE;
            end
         end
         STORE: begin
            busy      = 1'b1;
            storeEn   = 1'b1;
            stateNext = (sel == LAST_SEL) ? DONE : SETTLE;
         end
         DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            stateNext = cont_i ? SETTLE : IDLE;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // ------------------------------------------------- sequencing datapath
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sel        <= '0;
         tmr        <= '0;
         sweepCnt   <= '0;
         firstSweep <= 1'b1;
         for (int i = 0; i < NUM_OSC; i++) begin
            result[i] <= '0;
         end
      end else begin
         // The window timer restarts on every state change, so the same
         // counter times both the settle and the measurement windows.
         if (stateNext != state) begin
            tmr <= '0;
         end else if ((state == SETTLE) || (state == COUNT)) begin
            tmr <= tmr + TMR_W'(1);
         end

         if ((state == STORE) && (sel != LAST_SEL)) begin
            sel <= sel + SEL_W'(1);
         end else if (state == DONE) begin
            sel <= '0;
         end

         if (storeEn) begin
            result[sel] <= count;
         end

         if (state == DONE) begin
            sweepCnt   <= sweepCnt + SWEEP_CNT_W'(1);
            firstSweep <= 1'b0;
         end
      end
   end

   // ------------------------------------------------ baseline and alarm
`ifdef AGING_ALARM_EN
   logic [CNT_W-1:0]  baseline [NUM_OSC];
   logic [ADDR_W-1:0] baseOff;

   assign baseOff = rd_addr_i - ADDR_W'(NUM_OSC);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         alarmMask <= '0;
         for (int i = 0; i < NUM_OSC; i++) begin
            baseline[i] <= '0;
         end
      end else if (storeEn) begin
         if (firstSweep) begin
            baseline[sel] <= count;
         end else if ((count < baseline[sel]) && ((baseline[sel] - count) > thresh_i)) begin
            alarmMask[sel] <= 1'b1;
         end
      end
   end
`else
   logic unusedNoAlarm;

   assign alarmMask     = '0;
   assign unusedNoAlarm = ^{thresh_i, firstSweep};
`endif

   // ---------------------------------------------------------- read port
   // Registered read: a write in the same cycle lands after the read
   // samples the memory, so the pre-write value is returned.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rdData  <= '0;
         rdValid <= 1'b0;
      end else begin
         rdValid <= rd_en_i;
         if (rd_en_i) begin
            if (isResultAddr(32'(rd_addr_i), NUM_OSC)) begin
               rdData <= result[rdIdx];
            end
`ifdef AGING_ALARM_EN
            else if (isBaselineAddr(32'(rd_addr_i), NUM_OSC)) begin
               rdData <= baseline[baseOff[SEL_W-1:0]];
            end
`endif
            else begin
               rdData <= '0;
            end
         end
      end
   end

   assign test_en_o    = testEn;
   assign busy_o       = busy;
   assign done_o       = done;
   assign sweep_cnt_o  = sweepCnt;
   assign rd_data_o    = rdData;
   assign rd_valid_o   = rdValid;
   assign alarm_mask_o = alarmMask;
   assign alarm_o      = |alarmMask;

endmodule

// File: tb/tb_ro_aging_monitor.sv
// tb/tb_ro_aging_monitor.sv - scoreboard bench for ro_aging_monitor with default parameters

module tb_ro_aging_monitor;

   localparam int NUM_OSC   = 10;
   localparam int CNT_W     = 24;
   localparam int ADDR_W    = 5;
   localparam int SWEEP_LEN = 10 * (16 + 1024 + 1) + 1;   // 10411
`ifdef AGING_ALARM_EN
   localparam bit ALARM = 1'b1;
`else
   localparam bit ALARM = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               rstn = 1'b0;
   logic               start_i = 1'b0;
   logic               cont_i = 1'b0;
   logic [NUM_OSC-1:0] osc_i = '0;
   logic [CNT_W-1:0]   thresh_i = 24'd100;
   logic [NUM_OSC-1:0] test_en_o;
   logic               busy_o;
   logic               done_o;
   logic [15:0]        sweep_cnt_o;
   logic               rd_en_i = 1'b0;
   logic [ADDR_W-1:0]  rd_addr_i = '0;
   logic [CNT_W-1:0]   rd_data_o;
   logic               rd_valid_o;
   logic               alarm_o;
   logic [NUM_OSC-1:0] alarm_mask_o;

   ro_aging_monitor dut (
      .clk          (clk),
      .rstn         (rstn),
      .start_i      (start_i),
      .cont_i       (cont_i),
      .osc_i        (osc_i),
      .thresh_i     (thresh_i),
      .test_en_o    (test_en_o),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .sweep_cnt_o  (sweep_cnt_o),
      .rd_en_i      (rd_en_i),
      .rd_addr_i    (rd_addr_i),
      .rd_data_o    (rd_data_o),
      .rd_valid_o   (rd_valid_o),
      .alarm_o      (alarm_o),
      .alarm_mask_o (alarm_mask_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Oscillator model: halfPer[i] clk cycles per level, 0 holds the line low.
   int halfPer [NUM_OSC];
   int phase   [NUM_OSC];
   always @(posedge clk) begin
      #2;
      for (int i = 0; i < NUM_OSC; i++) begin
         if (halfPer[i] == 0) begin
            osc_i[i] = 1'b0;
         end else begin
            phase[i]++;
            if (phase[i] >= halfPer[i]) begin
               phase[i] = 0;
               osc_i[i] = ~osc_i[i];
            end
         end
      end
   end

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      string tag;
      int    lo;
      int    hi;
   } exp_t;
   exp_t expQ[$];
   exp_t monE;

   // Read scoreboard: every rd_valid_o pops one expectation.
   always @(negedge clk) begin
      if (rstn && rd_valid_o) begin
         vectors++;
         if (expQ.size() == 0) begin
            miscompares++;
            $display("FAIL rd_unexpected: got data %0d with no read pending", rd_data_o);
         end else begin
            monE = expQ.pop_front();
            if ((int'(rd_data_o) < monE.lo) || (int'(rd_data_o) > monE.hi)) begin
               miscompares++;
               $display("FAIL %s: got %0d, expected %0d..%0d", monE.tag, rd_data_o, monE.lo, monE.hi);
            end
         end
      end
   end

   int doneTotal = 0;
   always @(negedge clk) if (done_o === 1'b1) doneTotal++;

   bit watchBusy = 1'b0;
   bit busyDropped = 1'b0;
   always @(negedge clk) if (watchBusy && (busy_o !== 1'b1)) busyDropped = 1'b1;

   task automatic check(input string tag, input longint act, input longint exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pushExp(input string tag, input int lo, input int hi);
      exp_t e;
      e.tag = tag;
      e.lo  = lo;
      e.hi  = hi;
      expQ.push_back(e);
   endtask

   task automatic doRead(input int a, input int lo, input int hi, input string tag);
      @(negedge clk);
      rd_en_i   = 1'b1;
      rd_addr_i = ADDR_W'(a);
      pushExp(tag, lo, hi);
      @(negedge clk);
      rd_en_i = 1'b0;
   endtask

   task automatic startSweep(output int c0);
      @(negedge clk);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 0;
      c0 = cyc;
   endtask

   task automatic waitDone(input string tag, input int budget, output int at);
      int n = 0;
      while ((done_o !== 1'b1) && (n < budget)) begin
         @(negedge clk);
         n++;
      end
      at = cyc;
      if (done_o !== 1'b1) check(tag, 0, 1);
   endtask

   task automatic waitEnBit(input int b, input int budget);
      int n = 0;
      while ((test_en_o[b] !== 1'b1) && (n < budget)) begin
         @(negedge clk);
         n++;
      end
      if (test_en_o[b] !== 1'b1) check("wait_test_en", 0, 1);
   endtask

   task automatic waitStore(input int budget);
      int n = 0;
      while ((test_en_o !== '0) && (n < budget)) begin
         @(negedge clk);
         n++;
      end
      if (test_en_o !== '0) check("wait_store", 1, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got time limit, expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, tDone, d0, t1, t2, t3;
      for (int i = 0; i < NUM_OSC; i++) halfPer[i] = 1;

      // Reset state
      idle(3);
      check("rst_busy", busy_o, 0);
      check("rst_test_en", test_en_o, 0);
      check("rst_done", done_o, 0);
      check("rst_sweep_cnt", sweep_cnt_o, 0);
      check("rst_rd_valid", rd_valid_o, 0);
      check("rst_alarm_mask", alarm_mask_o, 0);
      rstn = 1'b1;
      idle(2);

      // Sweep A: channel 3 stuck low, a second start is ignored, read-during-write on ch9
      halfPer[3] = 0;
      d0 = doneTotal;
      startSweep(c0);
      check("start_busy", busy_o, 1);
      check("start_test_en", test_en_o, 1);
      idle(50);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      waitEnBit(9, 12000);
      waitStore(2000);
      rd_en_i   = 1'b1;
      rd_addr_i = ADDR_W'(9);
      pushExp("rd9_pre_write", 0, 0);
      @(negedge clk);
      rd_en_i = 1'b0;
      waitDone("sweepA_done_seen", 20, tDone);
      check("sweepA_length", tDone - c0 + 1, SWEEP_LEN);
      idle(5);
      check("sweepA_busy_low", busy_o, 0);
      check("sweepA_one_done", doneTotal - d0, 1);
      check("sweepA_sweep_cnt", sweep_cnt_o, 1);
      doRead(3, 0, 0, "res3_stuck");
      for (int i = 0; i < NUM_OSC; i++) begin
         if (i != 3) doRead(i, 511, 513, "resA_p2");
      end
      doRead(13, 0, 0, "base3_stuck");
      doRead(10, ALARM ? 511 : 0, ALARM ? 513 : 0, "base0");
      doRead(20, 0, 0, "addr20");
      doRead(31, 0, 0, "addr31");
      doRead(9, 511, 513, "rd9_post_write");

      // Reset in the middle of channel 4's count window
      halfPer[3] = 1;
      startSweep(c0);
      waitEnBit(4, 6000);
      idle(100);
      rstn = 1'b0;
      #1;
      check("mid_rst_busy", busy_o, 0);
      check("mid_rst_test_en", test_en_o, 0);
      check("mid_rst_done", done_o, 0);
      check("mid_rst_sweep_cnt", sweep_cnt_o, 0);
      check("mid_rst_rd_data", rd_data_o, 0);
      check("mid_rst_rd_valid", rd_valid_o, 0);
      check("mid_rst_alarm", alarm_o, 0);
      @(negedge clk);
      rstn = 1'b1;
      idle(2);
      for (int i = 0; i < 2 * NUM_OSC; i++) doRead(i, 0, 0, "post_rst_read");
      check("post_rst_sweep_cnt", sweep_cnt_o, 0);

      // Sweep B: restart after reset is a first sweep, all period 2
      startSweep(c0);
      waitDone("sweepB_done_seen", 12000, tDone);
      check("sweepB_length", tDone - c0 + 1, SWEEP_LEN);
      idle(3);
      check("sweepB_sweep_cnt", sweep_cnt_o, 1);
      doRead(3, 511, 513, "resB_ch3");

      // Continuous mode, channel 5 at period 4 for three sweeps
      halfPer[5] = 2;
      cont_i = 1'b1;
      d0 = doneTotal;
      startSweep(c0);
      watchBusy = 1'b1;
      waitDone("cont_done1_seen", 12000, t1);
      idle(1);
      waitDone("cont_done2_seen", 12000, t2);
      idle(1);
      cont_i = 1'b0;
      waitDone("cont_done3_seen", 12000, t3);
      watchBusy = 1'b0;
      check("cont_busy_at_done3", busy_o, 1);
      @(negedge clk);
      check("cont_busy_fall", busy_o, 0);
      check("cont_busy_never_dropped", busyDropped, 0);
      check("cont_first_length", t1 - c0 + 1, SWEEP_LEN);
      check("cont_spacing_1_2", t2 - t1, SWEEP_LEN);
      check("cont_spacing_2_3", t3 - t2, SWEEP_LEN);
      check("cont_done_count", doneTotal - d0, 3);
      idle(2);
      check("cont_sweep_cnt", sweep_cnt_o, 4);
      check("alarm_mask", alarm_mask_o, ALARM ? 32'h020 : 0);
      check("alarm_o", alarm_o, ALARM ? 1 : 0);
      doRead(5, 255, 257, "res5_p4");
      doRead(4, 511, 513, "res4_p2");
      doRead(15, ALARM ? 511 : 0, ALARM ? 513 : 0, "base5");
      doRead(20, 0, 0, "addr20_late");

      idle(5);
      check("scoreboard_drained", expQ.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
